// File: rtl/rom_stepper_if.sv
// rom_stepper_if: bundles the pattern-load port, playback controls and
// playback status of rom_stepper. master = controller/board top,
// slave = the sequencer itself.
interface rom_stepper_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
);
  // Pattern memory write port
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  // Playback control
  logic              start;
  logic              stop;
  logic              loop;
  logic              dir;
  logic [ADDR_W-1:0] first;
  logic [ADDR_W-1:0] last;
  // Playback status
  logic [WIDTH-1:0]  q;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              tick;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop, dir, first, last,
    input  q, addr, busy, tick, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop, dir, first, last,
    output q, addr, busy, tick, done
  );
endinterface

// File: rtl/rom_stepper.sv
// rom_stepper: DEPTH x WIDTH pattern memory stepped through an address
// window [first..last] once every TICK_DIV clocks, one-shot or looping,
// counting up or down modulo DEPTH.
// Ports: CLOCK_50 (rising edge), reset (synchronous, active-high),
//        bus (rom_stepper_if.slave: write port, start/stop/loop/dir/
//        first/last controls, q/addr/busy/tick/done status).
// Latency: addr and busy follow start on the sampling edge, q follows
// addr one edge later; tick/done are registered and coincide with the
// addr update of the step that produced them.
module rom_stepper #(
  parameter int WIDTH    = 8,
  parameter int ADDR_W   = 4,
  parameter int TICK_DIV = 50000000
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  rom_stepper_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  // Keep the divider at least one bit wide so TICK_DIV=1 still elaborates.
  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [WIDTH-1:0]  mem [DEPTH];

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DIV_W-1:0]  div_q,   div_d;
  logic              tick_q,  tick_d;
  logic              done_q,  done_d;
  logic [WIDTH-1:0]  q_q;

  logic              step;

  // A step fires on the last divider count; for TICK_DIV=1 DIV_MAX is 0
  // and the divider never leaves 0, so every RUN cycle is a step.
  assign step = (state_q == ST_RUN) && (div_q == DIV_MAX);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          addr_d  = bus.first;
          div_d   = '0;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          // stop beats a coincident start; addr freezes where it is
          state_d = ST_IDLE;
          div_d   = '0;
        end else if (bus.start) begin
          addr_d = bus.first;
          div_d  = '0;
        end else if (step) begin
          div_d  = '0;
          tick_d = 1'b1;
          if (addr_q == bus.last) begin
            done_d = 1'b1;
            if (bus.loop) begin
              addr_d = bus.first;
            end else begin
              state_d = ST_IDLE;
            end
          end else if (bus.dir) begin
            // Modulo-DEPTH arithmetic lets a window wrap through 0
            addr_d = addr_q - ADDR_W'(1);
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      div_q   <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
      // Reads the registered play address, so q trails addr by one edge and
      // a write to the addressed word shows up one edge after the write.
      q_q     <= mem[addr_q];
    end
  end

  // Pattern memory is deliberately untouched by reset so a loaded pattern
  // survives a board reset.
  always_ff @(posedge CLOCK_50) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.q    = q_q;
  assign bus.addr = addr_q;
  assign bus.busy = (state_q == ST_RUN);
  assign bus.tick = tick_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_rom_stepper.sv
// tb_rom_stepper: directed checks of rom_stepper with TICK_DIV=4 (dut_a)
// and TICK_DIV=1 (dut_b). Outputs are sampled 1 time unit after each
// rising edge; inputs are changed at the same point.
module tb_rom_stepper;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rom_stepper_if #(.WIDTH(8), .ADDR_W(4)) ifa ();
  rom_stepper_if #(.WIDTH(8), .ADDR_W(4)) ifb ();

  rom_stepper #(.WIDTH(8), .ADDR_W(4), .TICK_DIV(4)) dut_a (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (ifa.slave)
  );

  rom_stepper #(.WIDTH(8), .ADDR_W(4), .TICK_DIV(1)) dut_b (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (ifb.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] b_exp [9] = '{4'd1, 4'd0, 4'd15, 4'd14, 4'd1, 4'd0, 4'd15, 4'd14, 4'd1};

  initial begin
    int dones;

    ifa.wr_en = 0; ifa.wr_addr = 0; ifa.wr_data = 0;
    ifa.start = 0; ifa.stop = 0; ifa.loop = 0; ifa.dir = 0;
    ifa.first = 0; ifa.last = 0;
    ifb.wr_en = 0; ifb.wr_addr = 0; ifb.wr_data = 0;
    ifb.start = 0; ifb.stop = 0; ifb.loop = 0; ifb.dir = 0;
    ifb.first = 0; ifb.last = 0;

    // ---- reset state
    cyc(); cyc();
    check("rst_q",    32'(ifa.q),    32'h0);
    check("rst_addr", 32'(ifa.addr), 32'h0);
    check("rst_busy", 32'(ifa.busy), 32'h0);
    check("rst_tick", 32'(ifa.tick), 32'h0);
    check("rst_done", 32'(ifa.done), 32'h0);
    check("rst_busy_b", 32'(ifb.busy), 32'h0);
    rst = 0;

    // ---- load mem[i] = i + 0x10
    for (int i = 0; i < 16; i++) begin
      ifa.wr_en = 1; ifa.wr_addr = 4'(i); ifa.wr_data = 8'(i + 16);
      cyc();
    end
    ifa.wr_en = 0;

    // ---- one-shot up, window 2..5: steps at 4,8,12, done at 16
    ifa.first = 4'd2; ifa.last = 4'd5; ifa.loop = 0; ifa.dir = 0;
    ifa.start = 1;
    cyc();
    ifa.start = 0;
    check("os_busy0", 32'(ifa.busy), 32'h1);
    check("os_addr0", 32'(ifa.addr), 32'h2);
    check("os_tick0", 32'(ifa.tick), 32'h0);
    for (int c = 1; c <= 20; c++) begin
      logic [3:0] ea;
      cyc();
      ea = (c < 4) ? 4'd2 : (c < 8) ? 4'd3 : (c < 12) ? 4'd4 : 4'd5;
      check("os_addr", 32'(ifa.addr), 32'(ea));
      check("os_tick", 32'(ifa.tick), 32'(c == 4 || c == 8 || c == 12 || c == 16));
      check("os_done", 32'(ifa.done), 32'(c == 16));
      check("os_busy", 32'(ifa.busy), 32'(c < 16));
      if (c == 1)  check("os_q_first", 32'(ifa.q), 32'h12);
      if (c >= 13) check("os_q_last",  32'(ifa.q), 32'h15);
    end

    // ---- reset mid-run
    ifa.first = 4'd3; ifa.last = 4'd15; ifa.loop = 1; ifa.dir = 0;
    ifa.start = 1;
    cyc();
    ifa.start = 0;
    repeat (5) cyc();
    check("mr_running", 32'(ifa.addr), 32'h4);
    rst = 1;
    repeat (3) cyc();
    rst = 0;
    check("mr_q",    32'(ifa.q),    32'h0);
    check("mr_addr", 32'(ifa.addr), 32'h0);
    check("mr_busy", 32'(ifa.busy), 32'h0);
    check("mr_tick", 32'(ifa.tick), 32'h0);
    check("mr_done", 32'(ifa.done), 32'h0);
    cyc();
    check("mr_stay_idle", 32'(ifa.busy), 32'h0);

    // ---- start+stop together in RUN: stop wins
    ifa.first = 4'd3; ifa.last = 4'd9; ifa.loop = 1; ifa.dir = 0;
    ifa.start = 1;
    cyc();
    ifa.start = 0;
    repeat (5) cyc();
    check("ss_pre_addr", 32'(ifa.addr), 32'h4);
    ifa.start = 1; ifa.stop = 1;
    cyc();
    ifa.start = 0; ifa.stop = 0;
    check("ss_busy", 32'(ifa.busy), 32'h0);
    check("ss_addr", 32'(ifa.addr), 32'h4);
    check("ss_done", 32'(ifa.done), 32'h0);
    check("ss_tick", 32'(ifa.tick), 32'h0);
    repeat (3) cyc();
    check("ss_hold_addr", 32'(ifa.addr), 32'h4);
    ifa.stop = 1;
    cyc();
    ifa.stop = 0;
    check("stop_idle", 32'(ifa.busy), 32'h0);

    // ---- start alone mid-run: restart at first, divider restarted
    ifa.start = 1;
    cyc();
    ifa.start = 0;
    repeat (5) cyc();
    check("rs_pre_addr", 32'(ifa.addr), 32'h4);
    ifa.start = 1;
    cyc();
    ifa.start = 0;
    check("rs_addr", 32'(ifa.addr), 32'h3);
    check("rs_busy", 32'(ifa.busy), 32'h1);
    check("rs_done", 32'(ifa.done), 32'h0);
    for (int j = 1; j <= 4; j++) begin
      cyc();
      check("rs_tick", 32'(ifa.tick), 32'(j == 4));
      check("rs_step_addr", 32'(ifa.addr), (j == 4) ? 32'h4 : 32'h3);
    end
    ifa.stop = 1;
    cyc();
    ifa.stop = 0;

    // ---- live write to the addressed word, first=last=7 looping
    ifa.first = 4'd7; ifa.last = 4'd7; ifa.loop = 1;
    ifa.start = 1;
    cyc();
    ifa.start = 0;
    cyc(); cyc();
    check("lw_q_before", 32'(ifa.q), 32'h17);
    ifa.wr_en = 1; ifa.wr_addr = 4'd7; ifa.wr_data = 8'hAA;
    cyc();
    ifa.wr_en = 0;
    check("lw_q_old", 32'(ifa.q), 32'h17);
    cyc();
    check("lw_q_new", 32'(ifa.q),    32'hAA);
    check("lw_done",  32'(ifa.done), 32'h1);
    check("lw_tick",  32'(ifa.tick), 32'h1);
    check("lw_addr",  32'(ifa.addr), 32'h7);
    check("lw_busy",  32'(ifa.busy), 32'h1);
    ifa.stop = 1;
    cyc();
    ifa.stop = 0;

    // ---- clear loop mid-run: current pass completes, one done, IDLE
    ifa.first = 4'd0; ifa.last = 4'd2; ifa.loop = 1; ifa.dir = 0;
    ifa.start = 1;
    cyc();
    ifa.start = 0;
    repeat (12) cyc();
    check("mc_wrap_done", 32'(ifa.done), 32'h1);
    check("mc_wrap_addr", 32'(ifa.addr), 32'h0);
    check("mc_wrap_busy", 32'(ifa.busy), 32'h1);
    ifa.loop = 0;
    dones = 0;
    for (int j = 13; j <= 30; j++) begin
      cyc();
      if (ifa.done) dones++;
      if (j == 24) check("mc_end_done", 32'(ifa.done), 32'h1);
    end
    check("mc_done_count", 32'(dones),     32'h1);
    check("mc_busy",       32'(ifa.busy),  32'h0);
    check("mc_addr",       32'(ifa.addr),  32'h2);

    // ---- TICK_DIV=1 loop down 1..14 through the 0/15 wrap
    ifb.first = 4'd1; ifb.last = 4'd14; ifb.dir = 1; ifb.loop = 1;
    ifb.start = 1;
    cyc();
    ifb.start = 0;
    check("ld_addr0", 32'(ifb.addr), 32'(b_exp[0]));
    for (int c = 1; c <= 8; c++) begin
      cyc();
      check("ld_addr", 32'(ifb.addr), 32'(b_exp[c]));
      check("ld_tick", 32'(ifb.tick), 32'h1);
      check("ld_done", 32'(ifb.done), 32'(c == 4 || c == 8));
    end
    ifb.stop = 1;
    cyc();
    ifb.stop = 0;
    check("ld_stop_busy", 32'(ifb.busy), 32'h0);
    check("ld_stop_tick", 32'(ifb.tick), 32'h0);
    check("ld_stop_addr", 32'(ifb.addr), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_stepper.md
# rom_stepper

Parametrised pattern sequencer for the DE2 test designs, successor to the fixed 16-word ROM demo. Holds a DEPTH×WIDTH pattern memory, loaded through a write port, and steps through a programmable address window at a divided rate. Supports one-shot or loop playback and up or down direction. Output drives LEDR/LEDG or HEX decoders directly in board top levels.

## Interface
- WIDTH, 8: data word width.
- ADDR_W, 4: address width; DEPTH = 2**ADDR_W.
- TICK_DIV, 50000000: CLOCK_50 cycles per step; legal range ≥1.
- CLOCK_50 in 1: single clock, all logic on rising edge.
- reset in 1: synchronous, active-high.
- wr_en in 1: write strobe.
- wr_addr in ADDR_W: write address.
- wr_data in WIDTH: write data.
- start in 1: single-cycle pulse; begin or restart playback.
- stop in 1: single-cycle pulse; halt playback.
- loop in 1: 1 = wrap window forever, 0 = one-shot.
- dir in 1: 0 = step up, 1 = step down.
- first in ADDR_W: window start address.
- last in ADDR_W: window end address.
- q out WIDTH: registered mem[addr].
- addr out ADDR_W: current play address.
- busy out 1: high while in RUN.
- tick out 1: one-cycle pulse on each step.
- done out 1: one-cycle pulse at the end of each pass.

## Operation
- States: IDLE, RUN. Reset → IDLE, addr=0, q=0, divider=0, busy=0, tick=0, done=0.
- Memory is not cleared by reset. Simulation initial contents are 0.
- Write: wr_en=1 writes mem[wr_addr] at the edge, in any state, including during playback.
- Read: q <= mem[addr] every cycle. Write to the currently addressed word: q shows the old word on the cycle after the write, and the new word one cycle later.
- IDLE, start=1 → RUN; addr<=first; divider<=0.
- RUN, divider: counts 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0 and tick=1 for one cycle (registered, coincident with the addr update).
- RUN, on a step:
  - addr≠last: addr <= addr+1 (dir=0) or addr−1 (dir=1), modulo DEPTH. The window may therefore wrap through DEPTH-1↔0.
  - addr==last and loop=1: addr<=first; done=1; stay in RUN.
  - addr==last and loop=0: done=1; addr holds at last; → IDLE.
- first==last: every step is a pass end.
- Direction and window: if dir points away from last, the sequencer walks the full modulo ring until it reaches last. This is legal, not an error.
- loop, dir, first and last are sampled at each step. Changes mid-run take effect at the next step.
- stop in RUN → IDLE next edge. addr holds, divider<=0, no done, no tick.
- start in RUN: restart. addr<=first, divider<=0, no done.
- start and stop in the same cycle: stop wins.
- stop in IDLE: ignored.
- Reset mid-run overrides everything. Outputs take their reset values at that edge.

## Timing
- start sampled at edge k: busy=1 and addr=first after edge k. q=mem[first] after edge k+1.
- First step at edge k+TICK_DIV. Subsequent steps every TICK_DIV cycles.
- TICK_DIV=1: a step on every cycle in RUN, tick held high.
- One-shot pass of N addresses: busy falls at edge k+N·TICK_DIV, together with the done pulse.
- done and tick are asserted in the same cycle on a pass end.
- Write-to-q latency when addr==wr_addr: 2 cycles.

## Test plan
- Reset behaviour: reset high 3 cycles mid-run, TICK_DIV=4 → q=0, addr=0, busy=0, tick=0, done=0 on the cycle after reset.
- One-shot up, TICK_DIV=4: load mem[i]=i+0x10, first=2, last=5, loop=0, dir=0, start at cycle 0.
  - addr sequence 2,3,4,5 with steps at cycles 4, 8, 12.
  - done pulse plus busy falling at cycle 16; q=0x15 held afterwards.
- Loop down with ring wrap, TICK_DIV=1: first=1, last=14, dir=1, loop=1.
  - addr sequence 1,0,15,14,1,0…
  - done asserted each time addr 14→1.
- Stop/start priority:
  - start and stop in the same cycle while RUN → IDLE, addr unchanged, no done.
  - start alone mid-run → addr=first, divider restarted (next tick exactly TICK_DIV cycles later).
- Live write: during a loop with first=last=7, write mem[7]=0xAA → q=0xAA two cycles after the write edge, while playback continues uninterrupted.
- Mode change mid-run: clear loop during a looping pass → the pass completes at last, done pulses once, IDLE.
